// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack instruction-memory reader and a
// small FIFO presenting {instr_pc, instr} to the datapath over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem transfer on an edge with imem_req=1 and imem_ack=1, with
  // imem_req/imem_addr held stable until then; instr transfer on an edge with
  // instr_valid=1 and instr_ready=1. redirect overrides both in its cycle.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RESET_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic [31:0]     r_req_addr;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_fifo_pc    [DEPTH];
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic [CW-1:0]   w_count_next;
  logic [31:0]     w_redir_pc;
  logic [31:0]     w_next_pc;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  always_comb begin
    w_ack        = r_req & imem_ack;
    w_push       = (r_state == S_FETCH) & w_ack & ~redirect;
    w_pop        = (r_count != '0) & instr_ready & ~redirect;
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
    // Room is judged on the post-edge occupancy so a new request is only
    // launched when its data is guaranteed a free slot.
    w_room     = (w_count_next < CW'(DEPTH));
    w_redir_pc = {redirect_pc[31:2], 2'b00};
    w_next_pc  = r_fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_req_addr <= RESET_ALIGNED;
      r_fetch_pc <= RESET_ALIGNED;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          if (redirect) r_fetch_pc <= w_redir_pc;
        end
        S_FETCH: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            if (r_req && !imem_ack) begin
              r_state <= S_DRAIN;
            end else begin
              r_req      <= 1'b1;
              r_req_addr <= w_redir_pc;
            end
          end else if (w_ack) begin
            r_fetch_pc <= w_next_pc;
            r_req      <= w_room;
            r_req_addr <= w_next_pc;
          end else if (!r_req && w_room) begin
            r_req      <= 1'b1;
            r_req_addr <= r_fetch_pc;
          end
        end
        S_DRAIN: begin
          // The stale request keeps imem_req high; its data is never pushed.
          if (redirect) r_fetch_pc <= w_redir_pc;
          if (w_ack) begin
            r_state    <= S_FETCH;
            r_req_addr <= redirect ? w_redir_pc : r_fetch_pc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= 32'h0;
        r_fifo_instr[i] <= 32'h0;
      end
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= r_req_addr;
          r_fifo_instr[r_wr_ptr] <= imem_rdata;
          r_wr_ptr               <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_req_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory responder, randomized consumer and
// redirects, and a stream scoreboard built from the address-order rules.
module tb_fetch_unit;

  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  int ack_cnt  = 0;
  int fixed_wait = 0;
  bit rand_wait  = 0;

  bit          mem_in_req = 0;
  int          mem_waited = 0;
  int          mem_cur_wait = 0;
  logic [31:0] mem_held = 32'h0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next = RST_PC;
  logic [31:0] mon_e;
  bit          redir_seen = 0;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // memory responder: data = addr ^ KEY, configurable wait states
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_ack) mem_in_req = 0;
      imem_rdata = $urandom;
      if (reset && imem_req) begin
        if (!mem_in_req) begin
          mem_in_req   = 1;
          mem_held     = imem_addr;
          mem_waited   = 0;
          mem_cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
          chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        end else begin
          chk("addr_stable", imem_addr, mem_held);
        end
        if (mem_waited >= mem_cur_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ KEY;
          ack_cnt++;
        end else begin
          imem_ack = 1'b0;
          mem_waited++;
        end
      end else begin
        if (mem_in_req && reset) chk("req_hold", 32'(imem_req), 32'd1);
        mem_in_req = 0;
        imem_ack   = 1'b0;
      end
    end
  end

  // scoreboard: between redirects the stream is consecutive words from the target
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        exp_q.delete();
        exp_next   = RST_PC;
        redir_seen = 0;
      end else begin
        if (redir_seen) chk("flush_valid", 32'(instr_valid), 32'd0);
        redir_seen = 0;
        if (redirect) begin
          exp_q.delete();
          exp_next   = {redirect_pc[31:2], 2'b00};
          redir_seen = 1;
        end else if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
          end
          mon_e = exp_q.pop_front();
          chk("pop_pc", instr_pc, mon_e);
          chk("pop_instr", instr, mon_e ^ KEY);
          pops++;
        end
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  imem_addr, RST_PC);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"},    instr_pc, 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pops >= target) break;
      @(negedge clk);
    end
    chk(tag, 32'(pops >= target), 32'd1);
  endtask

  initial begin
    int v;
    int p0;
    reset       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // reset and start-up with zero-wait memory
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("e0_state", 32'(dbg_state), 32'd1);
    chk("e0_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("e1_req", 32'(imem_req), 32'd1);
    chk("e1_addr", imem_addr, RST_PC);
    chk("e1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("e2_valid", 32'(instr_valid), 32'd1);
    chk("e2_pc", instr_pc, 32'h0);
    chk("e2_instr", instr, KEY);
    chk("e2_addr", imem_addr, 32'h4);
    v = 0;
    repeat (16) begin
      @(negedge clk);
      if (instr_valid) v++;
    end
    chk("throughput", 32'(v), 32'd16);

    // backpressure: only DEPTH words fetched while the consumer stalls
    instr_ready = 1'b0;
    do_reset();
    ack_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_e1_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("bp_e2_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("bp_e3_req", 32'(imem_req), 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_acks", 32'(ack_cnt), 32'd2);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head", instr_pc, 32'h0);
    p0 = pops;
    instr_ready = 1'b1;
    wait_pops("bp_resume", p0 + 3, 12);

    // three wait states: one instruction every four cycles
    fixed_wait = 3;
    repeat (16) @(negedge clk);
    p0 = pops;
    repeat (40) @(negedge clk);
    chk("wait_rate", 32'(pops - p0), 32'd10);

    // redirect while the request to 0x10 is pending
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (imem_req && imem_addr == 32'h10) break;
      @(negedge clk);
    end
    chk("dr_reach_10", 32'(imem_req && imem_addr == 32'h10), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    chk("dr_state", 32'(dbg_state), 32'd2);
    chk("dr_req", 32'(imem_req), 32'd1);
    chk("dr_addr", imem_addr, 32'h10);
    chk("dr_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (imem_addr == 32'h200) break;
      @(negedge clk);
    end
    chk("dr_new_addr", imem_addr, 32'h200);
    chk("dr_fetch_state", 32'(dbg_state), 32'd1);
    wait_pops("dr_first", pops + 1, 20);

    // misaligned redirect in the same cycle as an ack
    fixed_wait = 0;
    repeat (10) @(negedge clk);
    chk("ac_req", 32'(imem_req), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    chk("ac_state", 32'(dbg_state), 32'd1);
    chk("ac_req_new", 32'(imem_req), 32'd1);
    chk("ac_addr", imem_addr, 32'h200);
    chk("ac_valid", 32'(instr_valid), 32'd0);
    wait_pops("ac_stream", pops + 2, 10);

    // address wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    wait_pops("wrap_stream", pops + 4, 12);

    // reset in the middle of a request
    fixed_wait = 3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    chk("mr_pending", 32'(imem_req), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_values("mr");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_e0_state", 32'(dbg_state), 32'd1);
    @(negedge clk);
    chk("mr_e1_req", 32'(imem_req), 32'd1);
    chk("mr_e1_addr", imem_addr, RST_PC);

    // randomized traffic: wait states, stalls and redirects
    rand_wait = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
    end
    @(negedge clk);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    p0 = pops;
    repeat (30) @(negedge clk);
    chk("rand_live", 32'(pops > p0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
